// File: rtl/gt_trig_sched.sv
// Trigger time-stamp scheduler: round-robin arbitration of request edges, global-time capture
// into a first-word-fall-through FIFO, and a programmable dead time after each grant.
module gt_trig_sched #(
  parameter int NSRC      = 4,
  parameter int SRCW      = 2,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 adcclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NSRC-1:0]      req,
  input  logic [24:0]          gtime,
  input  logic [7:0]           deadtime,
  output logic [24:0]          ts_data,
  output logic [SRCW-1:0]      ts_src,
  output logic                 ts_valid,
  input  logic                 ts_ready,
  output logic                 busy,
  output logic [DEPTH_LOG:0]   fifo_cnt,
  output logic [15:0]          lost_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int EW    = 25 + SRCW;

  // Consumer handshake: an entry leaves the FIFO on a cycle where ts_valid and ts_ready are
  // both high; ts_data/ts_src are stable and meaningful whenever ts_valid is high.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DEAD  = 2'd2
  } state_t;

  state_t              state;
  logic [NSRC-1:0]     req_d;
  logic [NSRC-1:0]     pending;
  logic [SRCW-1:0]     ptr;
  logic [SRCW-1:0]     win;
  logic [7:0]          dcnt;

  logic [EW-1:0]        mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;

  logic [NSRC-1:0]     req_edge;
  logic [NSRC-1:0]     clr;
  logic [NSRC-1:0]     loss_vec;
  logic [NSRC-1:0]     pend_nxt;
  logic [SRCW-1:0]     win_c;
  logic                grant_go;
  logic                push_req;
  logic                full;
  logic                pop;
  logic                push_ok;
  logic                drop;
  logic [4:0]          loss_n;
  logic [16:0]         lost_sum;
  logic [15:0]         lost_nxt;

  assign req_edge = req & ~req_d;
  assign grant_go = (state == IDLE) && enable && (|pending);

  // Winner is the pending source at the smallest circular distance past the pointer.
  always_comb begin
    int best;
    int d;
    win_c = ptr;
    best  = NSRC;
    d     = 0;
    for (int i = 0; i < NSRC; i++) begin
      d = i - int'(ptr) - 1;
      if (d < 0) d = d + NSRC;
      if (pending[i] && (d < best)) begin
        best  = d;
        win_c = SRCW'(i);
      end
    end
  end

  // An edge on the source being granted this cycle re-arms it instead of counting as lost.
  always_comb begin
    clr = '0;
    if (grant_go) clr[win_c] = 1'b1;
    loss_vec = req_edge & pending & ~clr;
    pend_nxt = enable ? ((pending & ~clr) | req_edge) : '0;
  end

  assign push_req = (state == GRANT);
  assign full     = (fifo_cnt == (DEPTH_LOG+1)'(DEPTH));
  assign ts_valid = (fifo_cnt != '0);
  assign pop      = ts_valid && ts_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    loss_n = '0;
    for (int i = 0; i < NSRC; i++) loss_n = loss_n + {4'b0, loss_vec[i]};
    loss_n = loss_n + {4'b0, drop};
    if (!enable) loss_n = '0;
    lost_sum = {1'b0, lost_cnt} + {12'b0, loss_n};
    lost_nxt = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
  end

  always_ff @(posedge adcclk) begin
    if (reset) begin
      req_d    <= '0;
      pending  <= '0;
      lost_cnt <= '0;
    end else begin
      req_d    <= req;
      pending  <= pend_nxt;
      lost_cnt <= lost_nxt;
    end
  end

  always_ff @(posedge adcclk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      ptr   <= SRCW'(NSRC - 1);
      win   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_go) begin
            win   <= win_c;
            ptr   <= win_c;
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (deadtime != 8'd0) begin
            state <= DEAD;
            dcnt  <= deadtime;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DEAD: begin
          if (dcnt == 8'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            dcnt <= dcnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge adcclk) begin
    if (push_ok) mem[wr_ptr] <= {gtime, win};
  end

  always_ff @(posedge adcclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (DEPTH_LOG+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (DEPTH_LOG+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign ts_data = ts_valid ? mem[rd_ptr][EW-1:SRCW] : '0;
  assign ts_src  = ts_valid ? mem[rd_ptr][SRCW-1:0]  : '0;

endmodule

// File: tb/tb_gt_trig_sched.sv
// Bench for gt_trig_sched: directed scenarios with literal expectations plus a long random run,
// all cross-checked every cycle against a time-based behavioural model.
module tb_gt_trig_sched;

  localparam int NSRC      = 4;
  localparam int SRCW      = 2;
  localparam int DEPTH_LOG = 3;
  localparam int DEPTH     = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b1;
  logic [NSRC-1:0]      req = '0;
  logic [24:0]          gtime = 25'h100;
  logic [7:0]           deadtime = '0;
  logic [24:0]          ts_data;
  logic [SRCW-1:0]      ts_src;
  logic                 ts_valid;
  logic                 ts_ready = 1'b0;
  logic                 busy;
  logic [DEPTH_LOG:0]   fifo_cnt;
  logic [15:0]          lost_cnt;

  gt_trig_sched #(.NSRC(NSRC), .SRCW(SRCW), .DEPTH_LOG(DEPTH_LOG)) dut (
    .adcclk(clk), .reset(reset), .enable(enable), .req(req), .gtime(gtime),
    .deadtime(deadtime), .ts_data(ts_data), .ts_src(ts_src), .ts_valid(ts_valid),
    .ts_ready(ts_ready), .busy(busy), .fifo_cnt(fifo_cnt), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tick = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    tick++;
    gtime = 25'h100 + 25'(8 * tick);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step_cycle();
    step_cycle();
    reset = 1'b0;
  endtask

  // Behavioural model: the scheduler is free (IDLE) from cycle m_free onward; a grant decided in
  // cycle c stamps in c+1 and frees the scheduler deadtime cycles after that.
  logic [NSRC-1:0] m_req_d, m_pend;
  int  m_ptr, m_cyc, m_free, m_gcyc, m_gsrc, m_lost;
  bit  m_init = 1'b0;
  logic [26:0] exp_q[$];

  task automatic model_step();
    logic [NSRC-1:0] edges;
    int win, loss, s;
    bit pop, full;
    if (reset) begin
      m_req_d = '0; m_pend = '0; m_ptr = NSRC - 1; m_free = m_cyc + 1;
      m_gcyc = -1; m_gsrc = 0; m_lost = 0; exp_q.delete(); m_init = 1'b1;
      return;
    end
    if (!m_init) return;
    edges = req & ~m_req_d;
    win = -1;
    loss = 0;
    pop  = (exp_q.size() != 0) && ts_ready;
    full = (exp_q.size() == DEPTH);
    if (pop) void'(exp_q.pop_front());
    if (m_cyc >= m_free && enable && m_pend != '0) begin
      for (int k = 1; k <= NSRC; k++) begin
        s = (m_ptr + k) % NSRC;
        if (win < 0 && m_pend[s]) win = s;
      end
      m_ptr = win; m_gcyc = m_cyc + 1; m_gsrc = win; m_free = m_cyc + 2;
    end
    if (m_cyc == m_gcyc) begin
      if (full && !pop) begin
        if (enable) loss++;
      end else begin
        exp_q.push_back({gtime, 2'(m_gsrc)});
      end
      m_free = m_cyc + 1 + int'(deadtime);
    end
    if (!enable) m_pend = '0;
    else begin
      if (win >= 0) m_pend[win] = 1'b0;
      for (int i = 0; i < NSRC; i++)
        if (edges[i]) begin
          if (m_pend[i]) loss++;
          m_pend[i] = 1'b1;
        end
    end
    m_lost = (m_lost + loss > 65535) ? 65535 : m_lost + loss;
    m_req_d = req;
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", busy, 32'(m_cyc < m_free));
      chk("fifo_cnt", fifo_cnt, exp_q.size());
      chk("ts_valid", ts_valid, 32'(exp_q.size() != 0));
      chk("lost_cnt", lost_cnt, m_lost);
      if (exp_q.size() != 0) begin
        chk("ts_data", ts_data, exp_q[0][26:2]);
        chk("ts_src", ts_src, exp_q[0][1:0]);
      end
    end
    model_step();
    m_cyc++;
  end

  int n;
  logic [24:0] prev;

  initial begin
    m_cyc = 0;
    // Single request latency and dead time
    do_reset();
    enable = 1'b1; deadtime = 8'd4; ts_ready = 1'b0;
    repeat (3) step_cycle();
    req = 4'b0100; n = tick; step_cycle(); req = '0;
    step_cycle();
    chk("t1_busy_grant", busy, 1);
    chk("t1_valid_early", ts_valid, 0);
    step_cycle();
    chk("t1_valid", ts_valid, 1);
    chk("t1_src", ts_src, 2);
    chk("t1_data", ts_data, 25'h100 + 25'(8 * (n + 2)));
    chk("t1_cnt", fifo_cnt, 1);
    repeat (3) step_cycle();
    chk("t1_busy_dead_end", busy, 1);
    step_cycle();
    chk("t1_busy_off", busy, 0);

    // Simultaneous requests, deadtime 0
    do_reset();
    deadtime = 8'd0;
    step_cycle();
    req = 4'b1111; n = tick; step_cycle(); req = '0;
    repeat (12) step_cycle();
    chk("t2_cnt", fifo_cnt, 4);
    chk("t2_lost", lost_cnt, 0);
    ts_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_src", ts_src, k);
      chk("t2_data", ts_data, 25'h100 + 25'(8 * (n + 2 + 2 * k)));
      step_cycle();
    end
    ts_ready = 1'b0;
    chk("t2_empty", fifo_cnt, 0);

    // Round-robin fairness
    do_reset();
    step_cycle();
    req = 4'b0010; step_cycle(); req = '0; step_cycle();
    req = 4'b1001; step_cycle(); req = '0;
    repeat (8) step_cycle();
    chk("t3_cnt", fifo_cnt, 3);
    ts_ready = 1'b1;
    chk("t3_src0", ts_src, 1); step_cycle();
    chk("t3_src1", ts_src, 3); step_cycle();
    chk("t3_src2", ts_src, 0); step_cycle();
    ts_ready = 1'b0;

    // Loss during dead time
    do_reset();
    deadtime = 8'd20;
    for (int p = 0; p < 3; p++) begin
      req = 4'b0001; step_cycle(); req = '0;
      repeat (4) step_cycle();
    end
    repeat (50) step_cycle();
    chk("t4_cnt", fifo_cnt, 2);
    chk("t4_lost", lost_cnt, 1);

    // FIFO full
    do_reset();
    deadtime = 8'd0; ts_ready = 1'b0;
    for (int p = 0; p < 10; p++) begin
      req = 4'b0010; step_cycle(); req = '0;
      repeat (3) step_cycle();
    end
    repeat (4) step_cycle();
    chk("t5_cnt_full", fifo_cnt, 8);
    chk("t5_lost", lost_cnt, 2);
    chk("t5_valid", ts_valid, 1);
    ts_ready = 1'b1; prev = '0;
    for (int k = 0; k < 8; k++) begin
      chk("t5_src", ts_src, 1);
      chk("t5_order", 32'(ts_data > prev), 1);
      prev = ts_data;
      step_cycle();
    end
    ts_ready = 1'b0;
    chk("t5_drained", fifo_cnt, 0);

    // Reset while in DEAD with three entries
    do_reset();
    deadtime = 8'd0;
    step_cycle();
    req = 4'b0111; step_cycle(); req = '0;
    repeat (4) step_cycle();
    deadtime = 8'd5;
    repeat (2) step_cycle();
    chk("t6_busy_dead", busy, 1);
    chk("t6_cnt3", fifo_cnt, 3);
    reset = 1'b1; step_cycle(); reset = 1'b0;
    chk("t6_cnt_rst", fifo_cnt, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_valid_rst", ts_valid, 0);
    deadtime = 8'd0;

    // Enable low: pending cleared, edges ignored, lost_cnt held
    do_reset();
    deadtime = 8'd20;
    for (int p = 0; p < 3; p++) begin
      req = 4'b0001; step_cycle(); req = '0;
      repeat (3) step_cycle();
    end
    enable = 1'b0;
    for (int p = 0; p < 4; p++) begin
      req = 4'b1111; step_cycle(); req = '0;
      repeat (3) step_cycle();
    end
    repeat (30) step_cycle();
    chk("t7_cnt", fifo_cnt, 1);
    chk("t7_lost", lost_cnt, 1);
    enable = 1'b1;

    // Random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      req = req ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      enable = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 49) == 0) deadtime = 8'($urandom_range(0, 6));
      ts_ready = ((i / 400) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 799) == 0);
      step_cycle();
    end
    reset = 1'b0;
    req = '0;
    repeat (5) step_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gt_trig_sched.md
Name: gt_trig_sched

Overview:
- Trigger time-stamp scheduler in the ADC clock domain.
- Accepts trigger requests from NSRC sources (self-trigger, master trigger, test pulse, etc.) and arbitrates between them round-robin.
- For each granted request, captures the 25-bit global-time word (22-bit external counter plus 3-bit phase) into a small FWFT FIFO with the source id, then enforces a programmable dead time.
- The FIFO is read by the readout sequencer over a valid/ready handshake.

Parameters:
- NSRC, 4: number of trigger sources (2..8).
- SRCW, 2: source-id width, equal to clog2(NSRC).
- DEPTH_LOG, 3: FIFO depth is 2^DEPTH_LOG entries.

Ports:
- adcclk  in  1  ADC clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scheduler enable; request edges are ignored while low.
- req  in  NSRC  trigger request levels, already synchronous to adcclk; a rising edge is one request.
- gtime  in  25  latched global time {counter[21:0], phase[2:0]}.
- deadtime  in  8  dead time in adcclk cycles after each grant; 0 means no dead time.
- ts_data  out  25  time stamp at the FIFO head.
- ts_src  out  SRCW  source id at the FIFO head.
- ts_valid  out  1  FIFO not empty.
- ts_ready  in  1  consumer pop; an entry pops when ts_valid and ts_ready are both high.
- busy  out  1  high in GRANT and DEAD states.
- fifo_cnt  out  DEPTH_LOG+1  FIFO occupancy.
- lost_cnt  out  16  saturating count of lost triggers.

Behaviour:
- Reset: all outputs 0; FIFO empty; pending bits 0; FSM in IDLE; round-robin pointer = NSRC-1, so source 0 wins first.
- Edge detect:
  - req is registered once; edge[i] = req[i] & ~req_d[i].
  - With enable=1, an edge sets pending[i].
  - An edge while pending[i] is already set increments lost_cnt; pending stays 1.
- FSM states:
  - IDLE: if any pending bit is set, choose the winner by searching from pointer+1 upward with wrap. Register the winner, clear its pending bit, update the pointer, go to GRANT.
  - GRANT (1 cycle): write {gtime as sampled in this cycle, winner id} into the FIFO. Then go to DEAD if deadtime != 0, else to IDLE.
  - DEAD: load counter = deadtime on entry. Decrement each cycle; leave for IDLE in the cycle the counter reaches 1. This gives exactly deadtime cycles in DEAD.
  - deadtime is sampled at DEAD entry only; changes mid-DEAD have no effect.
- Latency: req high first sampled in cycle n → pending set at end of n → IDLE arbitrates in n+1 → GRANT in n+2 (stamp = gtime in n+2) → ts_valid high in n+3 (FIFO previously empty).
- Back-to-back grants with deadtime=0: one grant every 2 cycles (GRANT, IDLE).
- FIFO:
  - FWFT; ts_data and ts_src are valid whenever ts_valid is high.
  - Full with no pop in the GRANT cycle: entry dropped, lost_cnt++, FSM proceeds normally to DEAD/IDLE.
  - Full with a pop in the same cycle: push accepted; count unchanged.
  - Simultaneous push and pop at any occupancy: count unchanged, data order preserved.
  - Pop when empty is ignored.
  - Pointers wrap modulo 2^DEPTH_LOG.
- lost_cnt saturates at 0xFFFF. If two loss events occur in one cycle (pending overflow plus FIFO full), lost_cnt increments by 2, saturating.
- enable low:
  - Edges are ignored and all pending bits clear the next cycle.
  - A GRANT or DEAD in progress completes normally.
  - FIFO stays readable.
  - lost_cnt holds its value.
- Reset mid-operation (any state) returns everything to reset values in the next cycle; FIFO contents are discarded.

Test Plan:
- Single request: enable=1, deadtime=4, gtime increments by 8 per cycle starting at 0x000100. Pulse req[2] at cycle 10 → ts_valid at cycle 13; ts_src=2; ts_data = gtime of cycle 12; busy high cycles 12–16; fifo_cnt=1.
- Simultaneous requests: pulse req=4'b1111 in one cycle, deadtime=0 → four entries with sources 0,1,2,3 in that order, at 2-cycle spacing; lost_cnt=0.
- Round-robin fairness: after source 1 is granted, req[0] and req[3] pend together → source 3 served before 0.
- Dead-time loss: deadtime=20. Pulse req[0] three times, 5 cycles apart → the second pulse sets pending, the third increments lost_cnt to 1; 2 entries are written.
- FIFO full: ts_ready=0, deadtime=0, 10 separated pulses on req[1] → fifo_cnt=8, lost_cnt=2, ts_valid stays high. Then hold ts_ready=1 → 8 entries pop in order with increasing ts_data, and fifo_cnt reaches 0.
- Reset and enable: assert reset while in DEAD with fifo_cnt=3 → next cycle fifo_cnt=0, busy=0, ts_valid=0. With enable=0, pulses on req → no entries, lost_cnt unchanged.
